// File: rtl/float_stream_pkg.sv
// Shared constants and helpers for the float stream joiner and its FIFOs.
package float_stream_pkg;

  localparam int FLOAT_W = 32;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic xfer(input logic stb, input logic ack);
    return stb & ack;
  endfunction

endpackage

// File: rtl/float_stream_joiner_if.sv
// Operand/pair handshake bundle for float_stream_joiner.
interface float_stream_joiner_if
  import float_stream_pkg::*;
#(
  parameter int DATA_W = FLOAT_W,
  parameter int DEPTH  = 4
);
  localparam int LW = level_w(DEPTH);

  logic [DATA_W-1:0] i_A;
  logic              i_A_STB;
  logic              o_A_ACK;
  logic [DATA_W-1:0] i_B;
  logic              i_B_STB;
  logic              o_B_ACK;
  logic [DATA_W-1:0] o_A;
  logic [DATA_W-1:0] o_B;
  logic              o_AB_STB;
  logic              i_AB_ACK;
  logic [LW-1:0]     o_A_LEVEL;
  logic [LW-1:0]     o_B_LEVEL;

  modport master (
    input  i_A, i_A_STB, i_B, i_B_STB, i_AB_ACK,
    output o_A_ACK, o_B_ACK, o_A, o_B, o_AB_STB, o_A_LEVEL, o_B_LEVEL
  );

  modport slave (
    output i_A, i_A_STB, i_B, i_B_STB, i_AB_ACK,
    input  o_A_ACK, o_B_ACK, o_A, o_B, o_AB_STB, o_A_LEVEL, o_B_LEVEL
  );

endinterface

// File: rtl/stb_ack_fifo.sv
// Fall-through FIFO with stb/ack write side; ack is a flop that drops once full.
module stb_ack_fifo
  import float_stream_pkg::*;
#(
  parameter int DATA_W = FLOAT_W,
  parameter int DEPTH  = 4,
  localparam int LW    = level_w(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_stb,
  output logic              wr_ack,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_pop,
  output logic [LW-1:0]     level,
  output logic [LW-1:0]     level_nxt
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign push    = xfer(wr_stb, wr_ack);
  assign pop     = rd_pop && (level != '0);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + 1'b1;
    else if (pop && !push) level_nxt = level - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      wr_ack <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level  <= level_nxt;
      wr_ack <= (level_nxt != LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/float_stream_joiner.sv
// Pairs two buffered float streams; optional pair counter under FLOAT_JOINER_PAIR_CNT_EN.
module float_stream_joiner
  import float_stream_pkg::*;
#(
  parameter int DATA_W = FLOAT_W,
  parameter int DEPTH  = 4,
  localparam int LW    = level_w(DEPTH)
) (
  input  logic i_CLK,
  input  logic i_RST,
  float_stream_joiner_if.master bus
`ifdef FLOAT_JOINER_PAIR_CNT_EN
  ,
  output logic [31:0] o_PAIR_CNT
`endif
);

  logic          pair_stb;
  logic          pop;
  logic [LW-1:0] a_level_nxt;
  logic [LW-1:0] b_level_nxt;

  assign pop          = xfer(pair_stb, bus.i_AB_ACK);
  assign bus.o_AB_STB = pair_stb;

  stb_ack_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (i_CLK),
    .rst       (i_RST),
    .wr_data   (bus.i_A),
    .wr_stb    (bus.i_A_STB),
    .wr_ack    (bus.o_A_ACK),
    .rd_data   (bus.o_A),
    .rd_pop    (pop),
    .level     (bus.o_A_LEVEL),
    .level_nxt (a_level_nxt)
  );

  stb_ack_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (i_CLK),
    .rst       (i_RST),
    .wr_data   (bus.i_B),
    .wr_stb    (bus.i_B_STB),
    .wr_ack    (bus.o_B_ACK),
    .rd_data   (bus.o_B),
    .rd_pop    (pop),
    .level     (bus.o_B_LEVEL),
    .level_nxt (b_level_nxt)
  );

  // Pair valid is registered from the next-state levels so it comes straight from a flop.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) pair_stb <= 1'b0;
    else       pair_stb <= (a_level_nxt != '0) && (b_level_nxt != '0);
  end

`ifdef FLOAT_JOINER_PAIR_CNT_EN
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST)    o_PAIR_CNT <= '0;
    else if (pop) o_PAIR_CNT <= o_PAIR_CNT + 32'd1;
  end
`endif

endmodule
